// File: rtl/apb_mem_bridge.sv
// apb_mem_bridge: accepts one core load/store at a time and runs it as a single
// APB4 master transfer. Handles lane steering, load extension, misalignment and timeout.
module apb_mem_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_en,
    input  logic        mem_write_en,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [2:0]  mem_funct3,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_err,
    output logic [31:0] paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    output logic [3:0]  pstrb,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP,
        S_DRAIN
    } state_t;

    localparam logic [15:0] TIMEOUT_W = TIMEOUT[15:0];

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_addr_lo;
    logic [2:0]  r_funct3;
    logic        r_write;
    logic [15:0] r_wait_cnt;

    logic        w_req;
    logic        w_req_bad;
    logic        w_timeout;
    logic [31:0] w_st_data;
    logic [3:0]  w_st_strb;
    logic [7:0]  w_lane_b;
    logic [15:0] w_lane_h;
    logic [31:0] w_load_data;

    logic [31:0] w_paddr_nxt;
    logic        w_psel_nxt;
    logic        w_penable_nxt;
    logic        w_pwrite_nxt;
    logic [31:0] w_pwdata_nxt;
    logic [3:0]  w_pstrb_nxt;
    logic        w_ready_nxt;
    logic        w_err_nxt;
    logic [31:0] w_rdata_nxt;

    assign w_req     = mem_read_en | mem_write_en;
    assign w_timeout = (TIMEOUT_W != 16'd0) && (r_wait_cnt == TIMEOUT_W);

    // Requests rejected here complete immediately without touching the bus.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_req_bad = mem_read_en & mem_write_en;
        case (mem_funct3)
            3'b000, 3'b100: begin
            end
            3'b001, 3'b101: if (mem_addr[0]) w_req_bad = 1'b1;
            3'b010:         if (mem_addr[1:0] != 2'b00) w_req_bad = 1'b1;
            default:        w_req_bad = 1'b1;
        endcase
        if (mem_write_en && mem_funct3[2]) w_req_bad = 1'b1;
    end

    always_comb begin
        w_st_data = 32'h0;
        w_st_strb = 4'h0;
        if (mem_write_en) begin
            case (mem_funct3[1:0])
                2'b00: begin
                    w_st_data = {4{mem_wdata[7:0]}};
                    w_st_strb = 4'b0001 << mem_addr[1:0];
                end
                2'b01: begin
                    w_st_data = {2{mem_wdata[15:0]}};
                    w_st_strb = 4'b0011 << mem_addr[1:0];
                end
                default: begin
                    w_st_data = mem_wdata;
                    w_st_strb = 4'b1111;
                end
            endcase
        end
    end

    // Halfword loads are aligned, so only addr[1] picks the 16-bit lane.
    always_comb begin
        w_lane_b = prdata[{r_addr_lo, 3'b000} +: 8];
        w_lane_h = prdata[{r_addr_lo[1], 4'b0000} +: 16];
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_lane_b[7]}}, w_lane_b};
            3'b001:  w_load_data = {{16{w_lane_h[15]}}, w_lane_h};
            3'b100:  w_load_data = {24'h0, w_lane_b};
            3'b101:  w_load_data = {16'h0, w_lane_h};
            default: w_load_data = prdata;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_req) w_state_nxt = w_req_bad ? S_RESP : S_SETUP;
            S_SETUP:  w_state_nxt = S_ACCESS;
            S_ACCESS: if (pready || w_timeout) w_state_nxt = S_RESP;
            S_RESP:   w_state_nxt = S_DRAIN;
            S_DRAIN:  if (!w_req) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; APB address/data hold between transfers.
    always_comb begin
        w_paddr_nxt   = paddr;
        w_pwrite_nxt  = pwrite;
        w_pwdata_nxt  = pwdata;
        w_pstrb_nxt   = pstrb;
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
        w_ready_nxt   = 1'b0;
        w_err_nxt     = 1'b0;
        w_rdata_nxt   = 32'h0;
        case (r_state)
            S_IDLE: begin
                if (w_req && w_req_bad) begin
                    w_ready_nxt = 1'b1;
                    w_err_nxt   = 1'b1;
                end else if (w_req) begin
                    w_psel_nxt   = 1'b1;
                    w_paddr_nxt  = {mem_addr[31:2], 2'b00};
                    w_pwrite_nxt = mem_write_en;
                    w_pwdata_nxt = w_st_data;
                    w_pstrb_nxt  = w_st_strb;
                end
            end
            S_SETUP: begin
                w_psel_nxt    = 1'b1;
                w_penable_nxt = 1'b1;
            end
            S_ACCESS: begin
                if (pready) begin
                    w_ready_nxt = 1'b1;
                    w_err_nxt   = pslverr;
                    w_rdata_nxt = (!r_write && !pslverr) ? w_load_data : 32'h0;
                end else if (w_timeout) begin
                    w_ready_nxt = 1'b1;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_psel_nxt    = 1'b1;
                    w_penable_nxt = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr_lo  <= 2'b00;
            r_funct3   <= 3'b000;
            r_write    <= 1'b0;
            r_wait_cnt <= 16'd0;
            paddr      <= 32'h0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            pwdata     <= 32'h0;
            pstrb      <= 4'h0;
            mem_ready  <= 1'b0;
            mem_err    <= 1'b0;
            mem_rdata  <= 32'h0;
        end else begin
            r_state   <= w_state_nxt;
            paddr     <= w_paddr_nxt;
            psel      <= w_psel_nxt;
            penable   <= w_penable_nxt;
            pwrite    <= w_pwrite_nxt;
            pwdata    <= w_pwdata_nxt;
            pstrb     <= w_pstrb_nxt;
            mem_ready <= w_ready_nxt;
            mem_err   <= w_err_nxt;
            mem_rdata <= w_rdata_nxt;
            if (r_state == S_IDLE && w_req) begin
                r_addr_lo <= mem_addr[1:0];
                r_funct3  <= mem_funct3;
                r_write   <= mem_write_en;
            end
            if (w_state_nxt == S_SETUP) begin
                r_wait_cnt <= 16'd0;
            end else if (r_state == S_ACCESS && !pready) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_apb_mem_bridge.sv
// Bench for apb_mem_bridge: transaction-level model builds the expected per-cycle
// output timeline of each request; a single compare process checks it every cycle.
module tb_apb_mem_bridge;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_en, mem_write_en;
    logic [31:0] mem_addr, mem_wdata;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rdata;
    logic        mem_ready, mem_err;
    logic [31:0] paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready, pslverr;

    apb_mem_bridge #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_err(mem_err),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        psel, penable, pwrite;
        logic [31:0] paddr, pwdata;
        logic [3:0]  pstrb;
        logic        ready, err;
        logic [31:0] rdata;
    } snap_t;

    snap_t exp_q[$];
    snap_t cur;
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    endtask

    function automatic snap_t zero_snap();
        snap_t s;
        s.psel = 0; s.penable = 0; s.pwrite = 0;
        s.paddr = 0; s.pwdata = 0; s.pstrb = 0;
        s.ready = 0; s.err = 0; s.rdata = 0;
        return s;
    endfunction

    function automatic bit is_bad(input bit rd, input bit wr, input logic [2:0] f3,
                                  input logic [31:0] addr);
        int unsigned size;
        if (rd && wr) return 1;
        if (wr && f3 > 3'd2) return 1;
        if (!wr && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1;
        size = 1 << f3[1:0];
        return (addr % size) != 0;
    endfunction

    function automatic logic [31:0] load_value(input logic [31:0] data, input logic [31:0] addr,
                                               input logic [2:0] f3);
        logic [31:0] lane, v;
        lane = data >> (8 * (addr % 4));
        case (f3)
            3'd0: begin v = lane % 256;   if (v >= 128)   v = v - 256;   end
            3'd1: begin v = lane % 65536; if (v >= 32768) v = v - 65536; end
            3'd4: v = lane % 256;
            3'd5: v = lane % 65536;
            default: v = data;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wdata);
        case (f3)
            3'd0:    return (wdata % 256) * 32'h0101_0101;
            3'd1:    return (wdata % 65536) * 32'h0001_0001;
            default: return wdata;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [31:0] addr);
        case (f3)
            3'd0:    return 4'(1 << (addr % 4));
            3'd1:    return 4'(3 << (addr % 4));
            default: return 4'hF;
        endcase
    endfunction

    // Compare process: one expected snapshot per cycle while a timeline is queued.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check("psel", 32'(psel), 32'(cur.psel));
            check("penable", 32'(penable), 32'(cur.penable));
            check("mem_ready", 32'(mem_ready), 32'(cur.ready));
            if (cur.psel) begin
                check("paddr", paddr, cur.paddr);
                check("pwrite", 32'(pwrite), 32'(cur.pwrite));
                check("pwdata", pwdata, cur.pwdata);
                check("pstrb", 32'(pstrb), 32'(cur.pstrb));
            end
            if (cur.ready) begin
                check("mem_err", 32'(mem_err), 32'(cur.err));
                check("mem_rdata", mem_rdata, cur.rdata);
            end
        end
    end

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(zero_snap());
            @(posedge clk); #1;
        end
    endtask

    // Builds the expected timeline of one request, then drives it cycle by cycle.
    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] f3,
                           input logic [31:0] rdat, input bit slverr, input int waits,
                           input int hold, input bit drop_early);
        snap_t s;
        bit    bad, en;
        int    n_acc, r_idx, h, last, ready_idx;
        bad = is_bad(rd, wr, f3, addr);
        h = (bad || drop_early) ? 0 : hold;
        exp_q.push_back(zero_snap());
        if (bad) begin
            r_idx = 1;
            ready_idx = -1;
        end else begin
            s = zero_snap();
            s.psel   = 1;
            s.pwrite = wr;
            s.paddr  = addr - addr % 4;
            if (wr) begin
                s.pwdata = store_data(f3, wdata);
                s.pstrb  = store_strb(f3, addr);
            end
            exp_q.push_back(s);
            n_acc = (waits <= TO) ? waits + 1 : TO + 1;
            s.penable = 1;
            for (int i = 0; i < n_acc; i++) exp_q.push_back(s);
            r_idx = 2 + n_acc;
            ready_idx = (waits <= TO) ? 2 + waits : -1;
        end
        s = zero_snap();
        s.ready = 1;
        if (bad || waits > TO || slverr) s.err = 1;
        else if (!wr) s.rdata = load_value(rdat, addr, f3);
        exp_q.push_back(s);
        for (int i = 0; i <= h; i++) exp_q.push_back(zero_snap());
        last = r_idx + 1 + h;
        for (int i = 0; i <= last; i++) begin
            en = (drop_early && !bad) ? (i <= 1) : (i <= r_idx + h);
            mem_read_en  = rd & en;
            mem_write_en = wr & en;
            mem_addr     = addr;
            mem_wdata    = wdata;
            mem_funct3   = f3;
            prdata       = rdat;
            pslverr      = slverr;
            pready       = (i == ready_idx);
            @(posedge clk); #1;
        end
        mem_read_en  = 0;
        mem_write_en = 0;
        pready       = 0;
        pslverr      = 0;
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] addr;
        int          kind, waits;
        bit          rd, wr;

        rst = 1; mem_read_en = 0; mem_write_en = 0;
        mem_addr = 0; mem_wdata = 0; mem_funct3 = 0;
        prdata = 0; pready = 0; pslverr = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_psel", 32'(psel), 0);
        check("rst_penable", 32'(penable), 0);
        check("rst_mem_ready", 32'(mem_ready), 0);
        check("rst_mem_err", 32'(mem_err), 0);
        check("rst_mem_rdata", mem_rdata, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwdata", pwdata, 0);
        check("rst_pstrb", 32'(pstrb), 0);
        rst = 0;
        @(posedge clk); #1;

        // Hand-computed expectations that pin the model.
        check("pin_lb", load_value(32'h0080_0000, 32'h3002, 3'd0), 32'hFFFF_FF80);
        check("pin_lbu", load_value(32'h0080_0000, 32'h3002, 3'd4), 32'h0000_0080);
        check("pin_lh", load_value(32'h8001_0000, 32'h3002, 3'd1), 32'hFFFF_8001);
        check("pin_lw", load_value(32'hDEAD_BEEF, 32'h1000, 3'd2), 32'hDEAD_BEEF);
        check("pin_sb_data", store_data(3'd0, 32'h0000_00A5), 32'hA5A5_A5A5);
        check("pin_sb_strb", 32'(store_strb(3'd0, 32'h2003)), 32'h8);
        check("pin_bad_lw", 32'(is_bad(1, 0, 3'd2, 32'h4002)), 1);
        check("pin_bad_sh", 32'(is_bad(0, 1, 3'd1, 32'h4001)), 1);
        check("pin_bad_f3", 32'(is_bad(1, 0, 3'd3, 32'h4000)), 1);
        check("pin_ok_lw", 32'(is_bad(1, 0, 3'd2, 32'h1000)), 0);

        // Directed cases from the plan, checked cycle by cycle.
        run_txn(1, 0, 32'h1000, 0, 3'd2, 32'hDEAD_BEEF, 0, 0, 0, 0);
        run_txn(0, 1, 32'h2003, 32'h0000_00A5, 3'd0, 0, 0, 2, 0, 0);
        run_txn(1, 0, 32'h3002, 0, 3'd0, 32'h0080_0000, 0, 0, 1, 0);
        run_txn(1, 0, 32'h3002, 0, 3'd4, 32'h0080_0000, 0, 1, 0, 0);
        run_txn(1, 0, 32'h3002, 0, 3'd1, 32'h8001_0000, 0, 0, 0, 0);
        run_txn(1, 0, 32'h4002, 0, 3'd2, 0, 0, 0, 0, 0);
        run_txn(0, 1, 32'h4001, 32'h1234, 3'd1, 0, 0, 0, 2, 0);
        run_txn(1, 0, 32'h4000, 0, 3'd3, 0, 0, 0, 0, 0);
        run_txn(1, 1, 32'h4000, 0, 3'd2, 0, 0, 0, 0, 0);
        run_txn(1, 0, 32'h5000, 0, 3'd2, 32'h1111_2222, 0, 10, 0, 0);
        run_txn(1, 0, 32'h5004, 0, 3'd2, 32'h3333_4444, 0, TO, 0, 0);
        run_txn(0, 1, 32'h5008, 32'hCAFE_F00D, 3'd2, 0, 0, TO + 1, 0, 0);
        run_txn(1, 0, 32'h6000, 0, 3'd2, 32'h5555_6666, 1, 1, 0, 0);
        run_txn(0, 1, 32'h6002, 32'hBEEF, 3'd1, 0, 0, 0, 0, 1);

        // Reset while in ACCESS, then a normal load.
        mem_read_en = 1; mem_addr = 32'h7000; mem_funct3 = 3'd2; pready = 0;
        @(posedge clk); #1;
        check("pre_rst_setup_psel", 32'(psel), 1);
        @(posedge clk); #1;
        check("pre_rst_access_penable", 32'(penable), 1);
        rst = 1;
        @(posedge clk); #1;
        check("mid_rst_psel", 32'(psel), 0);
        check("mid_rst_penable", 32'(penable), 0);
        check("mid_rst_mem_ready", 32'(mem_ready), 0);
        rst = 0; mem_read_en = 0;
        @(posedge clk); #1;
        check("post_rst_mem_ready", 32'(mem_ready), 0);
        run_txn(1, 0, 32'h7000, 0, 3'd2, 32'h0BAD_CAFE, 0, 0, 0, 0);

        // Randomised traffic.
        for (int t = 0; t < 300; t++) begin
            kind = int'($urandom_range(0, 19));
            rd = (kind >= 1 && kind <= 10) || kind == 0;
            wr = (kind > 10) || kind == 0;
            if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
            else if (wr) f3 = 3'($urandom_range(0, 2));
            else begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
            end
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr - addr % (1 << f3[1:0]);
            waits = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO - 1, TO + 2))
                                                : int'($urandom_range(0, 3));
            idle_cycles(int'($urandom_range(0, 2)));
            run_txn(rd, wr, addr, $urandom, f3, $urandom, ($urandom_range(0, 7) == 0),
                    waits, int'($urandom_range(0, 2)), ($urandom_range(0, 9) == 0));
        end

        idle_cycles(2);
        @(posedge clk); #1;
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
